// File: rtl/perf_cfg_axi_master.sv
// rtl/perf_cfg_axi_master.sv - single-beat AXI4 config initiator for the perf monitor slave port
module perf_cfg_axi_master #(
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 64,
    parameter int ID_WIDTH       = 4,
    parameter int AXI_ID         = 0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    // command port
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_write_i,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [DATA_WIDTH-1:0]   req_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] req_wstrb_i,
    // response port
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic [1:0]              rsp_resp_o,
    output logic                    rsp_timeout_o,
    // AW channel
    output logic                    aw_valid_o,
    output logic [ADDR_WIDTH-1:0]   aw_addr_o,
    output logic [7:0]              aw_len_o,
    output logic [2:0]              aw_size_o,
    output logic [ID_WIDTH-1:0]     aw_id_o,
    input  logic                    aw_ready_i,
    // W channel
    output logic                    w_valid_o,
    output logic [DATA_WIDTH-1:0]   w_data_o,
    output logic [DATA_WIDTH/8-1:0] w_strb_o,
    output logic                    w_last_o,
    input  logic                    w_ready_i,
    // B channel
    input  logic                    b_valid_i,
    input  logic [1:0]              b_resp_i,
    input  logic [ID_WIDTH-1:0]     b_id_i,
    output logic                    b_ready_o,
    // AR channel
    output logic                    ar_valid_o,
    output logic [ADDR_WIDTH-1:0]   ar_addr_o,
    output logic [7:0]              ar_len_o,
    output logic [2:0]              ar_size_o,
    output logic [ID_WIDTH-1:0]     ar_id_o,
    input  logic                    ar_ready_i,
    // R channel
    input  logic                    r_valid_i,
    input  logic [DATA_WIDTH-1:0]   r_data_i,
    input  logic [1:0]              r_resp_i,
    input  logic                    r_last_i,
    input  logic [ID_WIDTH-1:0]     r_id_i,
    output logic                    r_ready_o
);

    localparam int                STRB_W      = DATA_WIDTH / 8;
    localparam logic [2:0]        AXSIZE      = 3'($clog2(STRB_W));
    localparam logic [ID_WIDTH-1:0] ID_VAL    = ID_WIDTH'(AXI_ID);
    localparam int                CNT_W       = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0]  WD_MAX      = CNT_W'(TIMEOUT_CYCLES);
    localparam logic              WD_ENABLE   = (TIMEOUT_CYCLES > 0);
    localparam logic [1:0]        RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        DRAIN,
        RSP
    } state_t;

    state_t                  r_state;
    logic                    r_is_write;
    logic [CNT_W-1:0]        r_wd_cnt;

    logic                    r_req_ready;
    logic                    r_rsp_valid;
    logic [DATA_WIDTH-1:0]   r_rsp_rdata;
    logic [1:0]              r_rsp_resp;
    logic                    r_rsp_timeout;

    logic                    r_aw_valid;
    logic [ADDR_WIDTH-1:0]   r_aw_addr;
    logic [2:0]              r_aw_size;
    logic [ID_WIDTH-1:0]     r_aw_id;
    logic                    r_w_valid;
    logic [DATA_WIDTH-1:0]   r_w_data;
    logic [STRB_W-1:0]       r_w_strb;
    logic                    r_w_last;
    logic                    r_b_ready;
    logic                    r_ar_valid;
    logic [ADDR_WIDTH-1:0]   r_ar_addr;
    logic [2:0]              r_ar_size;
    logic [ID_WIDTH-1:0]     r_ar_id;
    logic                    r_r_ready;

    logic w_aw_hs;
    logic w_w_hs;
    logic w_ar_hs;
    logic w_b_match;
    logic w_r_match;
    logic w_wd_expired;
    logic w_late_beat;

    assign w_aw_hs      = r_aw_valid && aw_ready_i;
    assign w_w_hs       = r_w_valid && w_ready_i;
    assign w_ar_hs      = r_ar_valid && ar_ready_i;
    assign w_b_match    = b_valid_i && (b_id_i == ID_VAL);
    assign w_r_match    = r_valid_i && (r_id_i == ID_VAL);
    assign w_wd_expired = WD_ENABLE && (r_wd_cnt == WD_MAX);
    assign w_late_beat  = r_is_write ? w_b_match : w_r_match;

    // Command FSM: every AXI and response output is a register owned by this block.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= IDLE;
            r_is_write    <= 1'b0;
            r_wd_cnt      <= '0;
            r_req_ready   <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_resp    <= 2'b00;
            r_rsp_timeout <= 1'b0;
            r_aw_valid    <= 1'b0;
            r_aw_addr     <= '0;
            r_aw_size     <= 3'd0;
            r_aw_id       <= '0;
            r_w_valid     <= 1'b0;
            r_w_data      <= '0;
            r_w_strb      <= '0;
            r_w_last      <= 1'b0;
            r_b_ready     <= 1'b0;
            r_ar_valid    <= 1'b0;
            r_ar_addr     <= '0;
            r_ar_size     <= 3'd0;
            r_ar_id       <= '0;
            r_r_ready     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_req_ready <= 1'b1;
                    if (req_valid_i && r_req_ready) begin
                        r_req_ready <= 1'b0;
                        r_is_write  <= req_write_i;
                        r_aw_size   <= AXSIZE;
                        r_ar_size   <= AXSIZE;
                        r_aw_id     <= ID_VAL;
                        r_ar_id     <= ID_VAL;
                        r_w_last    <= 1'b1;
                        if (req_write_i) begin
                            r_aw_addr  <= req_addr_i;
                            r_w_data   <= req_wdata_i;
                            r_w_strb   <= req_wstrb_i;
                            r_aw_valid <= 1'b1;
                            r_w_valid  <= 1'b1;
                            r_state    <= WR_REQ;
                        end else begin
                            r_ar_addr  <= req_addr_i;
                            r_ar_valid <= 1'b1;
                            r_state    <= RD_REQ;
                        end
                    end
                end

                WR_REQ: begin
                    // AW and W retire independently; leave once both have handshaked.
                    if (w_aw_hs) r_aw_valid <= 1'b0;
                    if (w_w_hs)  r_w_valid  <= 1'b0;
                    if ((!r_aw_valid || w_aw_hs) && (!r_w_valid || w_w_hs)) begin
                        r_b_ready <= 1'b1;
                        r_wd_cnt  <= '0;
                        r_state   <= WR_RESP;
                    end
                end

                WR_RESP: begin
                    // Beats with a foreign ID are accepted by b_ready and dropped here.
                    if (w_b_match) begin
                        r_b_ready     <= 1'b0;
                        r_rsp_rdata   <= '0;
                        r_rsp_resp    <= b_resp_i;
                        r_rsp_timeout <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= RSP;
                    end else if (w_wd_expired) begin
                        r_rsp_rdata   <= '0;
                        r_rsp_resp    <= RESP_SLVERR;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= DRAIN;
                    end else if (r_wd_cnt != WD_MAX) begin
                        r_wd_cnt <= r_wd_cnt + CNT_W'(1);
                    end
                end

                RD_REQ: begin
                    if (w_ar_hs) begin
                        r_ar_valid <= 1'b0;
                        r_r_ready  <= 1'b1;
                        r_wd_cnt   <= '0;
                        r_state    <= RD_RESP;
                    end
                end

                RD_RESP: begin
                    // A single-beat read must carry last; otherwise report it as a slave error.
                    if (w_r_match) begin
                        r_r_ready     <= 1'b0;
                        r_rsp_rdata   <= r_data_i;
                        r_rsp_resp    <= r_last_i ? r_resp_i : RESP_SLVERR;
                        r_rsp_timeout <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= RSP;
                    end else if (w_wd_expired) begin
                        r_rsp_rdata   <= '0;
                        r_rsp_resp    <= RESP_SLVERR;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= DRAIN;
                    end else if (r_wd_cnt != WD_MAX) begin
                        r_wd_cnt <= r_wd_cnt + CNT_W'(1);
                    end
                end

                DRAIN: begin
                    // The timeout response may be taken while the late beat is still owed;
                    // no new command is accepted until that beat has been swallowed.
                    if (r_rsp_valid && rsp_ready_i) r_rsp_valid <= 1'b0;
                    if (w_late_beat) begin
                        r_b_ready <= 1'b0;
                        r_r_ready <= 1'b0;
                        if (r_rsp_valid && !rsp_ready_i) begin
                            r_state <= RSP;
                        end else begin
                            r_req_ready <= 1'b1;
                            r_state     <= IDLE;
                        end
                    end
                end

                RSP: begin
                    if (rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready_o   = r_req_ready;
    assign rsp_valid_o   = r_rsp_valid;
    assign rsp_rdata_o   = r_rsp_rdata;
    assign rsp_resp_o    = r_rsp_resp;
    assign rsp_timeout_o = r_rsp_timeout;

    assign aw_valid_o = r_aw_valid;
    assign aw_addr_o  = r_aw_addr;
    assign aw_len_o   = 8'd0;
    assign aw_size_o  = r_aw_size;
    assign aw_id_o    = r_aw_id;

    assign w_valid_o  = r_w_valid;
    assign w_data_o   = r_w_data;
    assign w_strb_o   = r_w_strb;
    assign w_last_o   = r_w_last;

    assign b_ready_o  = r_b_ready;

    assign ar_valid_o = r_ar_valid;
    assign ar_addr_o  = r_ar_addr;
    assign ar_len_o   = 8'd0;
    assign ar_size_o  = r_ar_size;
    assign ar_id_o    = r_ar_id;

    assign r_ready_o  = r_r_ready;

endmodule

// File: tb/tb_perf_cfg_axi_master.sv
// tb/tb_perf_cfg_axi_master.sv - scoreboard bench for perf_cfg_axi_master
module tb_perf_cfg_axi_master;

    localparam int AW  = 64;
    localparam int DW  = 64;
    localparam int IW  = 4;
    localparam int ID  = 3;
    localparam int TMO = 8;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            req_valid_i, req_ready_o, req_write_i;
    logic [AW-1:0]   req_addr_i;
    logic [DW-1:0]   req_wdata_i;
    logic [DW/8-1:0] req_wstrb_i;
    logic            rsp_valid_o, rsp_ready_i;
    logic [DW-1:0]   rsp_rdata_o;
    logic [1:0]      rsp_resp_o;
    logic            rsp_timeout_o;
    logic            aw_valid_o, aw_ready_i;
    logic [AW-1:0]   aw_addr_o;
    logic [7:0]      aw_len_o;
    logic [2:0]      aw_size_o;
    logic [IW-1:0]   aw_id_o;
    logic            w_valid_o, w_last_o, w_ready_i;
    logic [DW-1:0]   w_data_o;
    logic [DW/8-1:0] w_strb_o;
    logic            b_valid_i, b_ready_o;
    logic [1:0]      b_resp_i;
    logic [IW-1:0]   b_id_i;
    logic            ar_valid_o, ar_ready_i;
    logic [AW-1:0]   ar_addr_o;
    logic [7:0]      ar_len_o;
    logic [2:0]      ar_size_o;
    logic [IW-1:0]   ar_id_o;
    logic            r_valid_i, r_last_i, r_ready_o;
    logic [DW-1:0]   r_data_i;
    logic [1:0]      r_resp_i;
    logic [IW-1:0]   r_id_i;

    perf_cfg_axi_master #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .AXI_ID(ID), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_wstrb_i(req_wstrb_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
        .rsp_resp_o(rsp_resp_o), .rsp_timeout_o(rsp_timeout_o),
        .aw_valid_o(aw_valid_o), .aw_addr_o(aw_addr_o), .aw_len_o(aw_len_o),
        .aw_size_o(aw_size_o), .aw_id_o(aw_id_o), .aw_ready_i(aw_ready_i),
        .w_valid_o(w_valid_o), .w_data_o(w_data_o), .w_strb_o(w_strb_o),
        .w_last_o(w_last_o), .w_ready_i(w_ready_i),
        .b_valid_i(b_valid_i), .b_resp_i(b_resp_i), .b_id_i(b_id_i), .b_ready_o(b_ready_o),
        .ar_valid_o(ar_valid_o), .ar_addr_o(ar_addr_o), .ar_len_o(ar_len_o),
        .ar_size_o(ar_size_o), .ar_id_o(ar_id_o), .ar_ready_i(ar_ready_i),
        .r_valid_i(r_valid_i), .r_data_i(r_data_i), .r_resp_i(r_resp_i),
        .r_last_i(r_last_i), .r_id_i(r_id_i), .r_ready_o(r_ready_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [DW-1:0] rdata;
        logic [1:0]    resp;
        logic          tmo;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [DW-1:0] rdata, input logic [1:0] resp, input logic tmo);
        exp_t e;
        e.rdata = rdata;
        e.resp  = resp;
        e.tmo   = tmo;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        req_valid_i = 1'b1;
        req_write_i = wr;
        req_addr_i  = addr;
        req_wdata_i = wd;
        req_wstrb_i = 8'hFF;
        step();
        req_valid_i = 1'b0;
    endtask

    // Response monitor: each completed rsp handshake pops one scoreboard entry.
    always @(negedge clk_i) begin
        if (rst_ni && rsp_valid_o && rsp_ready_i) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_rdata", rsp_rdata_o, e.rdata);
                chk("rsp_resp", 64'(rsp_resp_o), 64'(e.resp));
                chk("rsp_timeout", 64'(rsp_timeout_o), 64'(e.tmo));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL sim_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        rst_ni = 1'b0;
        req_valid_i = 0; req_write_i = 0; req_addr_i = '0; req_wdata_i = '0; req_wstrb_i = '0;
        rsp_ready_i = 1'b1;
        aw_ready_i = 0; w_ready_i = 0; ar_ready_i = 0;
        b_valid_i = 0; b_resp_i = 0; b_id_i = 0;
        r_valid_i = 0; r_data_i = '0; r_resp_i = 0; r_last_i = 0; r_id_i = 0;

        // reset values
        step(); step();
        chk("rst_req_ready", 64'(req_ready_o), 64'd0);
        chk("rst_aw_valid", 64'(aw_valid_o), 64'd0);
        chk("rst_aw_size", 64'(aw_size_o), 64'd0);
        chk("rst_w_last", 64'(w_last_o), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        rst_ni = 1'b1;
        step();
        chk("idle_req_ready", 64'(req_ready_o), 64'd1);

        // zero-wait write
        aw_ready_i = 1; w_ready_i = 1;
        push_exp('0, 2'b00, 1'b0);
        issue(1'b1, 64'h10, 64'h1);
        chk("wr_aw_valid_c1", 64'(aw_valid_o), 64'd1);
        chk("wr_w_valid_c1", 64'(w_valid_o), 64'd1);
        chk("wr_aw_addr", aw_addr_o, 64'h10);
        chk("wr_w_data", w_data_o, 64'h1);
        chk("wr_w_strb", 64'(w_strb_o), 64'hFF);
        chk("wr_aw_size", 64'(aw_size_o), 64'd3);
        chk("wr_aw_id", 64'(aw_id_o), 64'(ID));
        chk("wr_aw_len", 64'(aw_len_o), 64'd0);
        chk("wr_w_last", 64'(w_last_o), 64'd1);
        chk("wr_req_ready_busy", 64'(req_ready_o), 64'd0);
        step();
        chk("wr_aw_valid_c2", 64'(aw_valid_o), 64'd0);
        chk("wr_b_ready_c2", 64'(b_ready_o), 64'd1);
        b_valid_i = 1; b_id_i = 4'(ID); b_resp_i = 2'b00;
        step();
        b_valid_i = 0;
        chk("wr_rsp_valid_c3", 64'(rsp_valid_o), 64'd1);
        chk("wr_b_ready_c3", 64'(b_ready_o), 64'd0);
        step();
        chk("wr_rsp_valid_c4", 64'(rsp_valid_o), 64'd0);
        chk("wr_req_ready_c4", 64'(req_ready_o), 64'd1);

        // zero-wait read
        ar_ready_i = 1;
        push_exp(64'hDEADBEEF_CAFEF00D, 2'b00, 1'b0);
        issue(1'b0, 64'h18, '0);
        chk("rd_ar_valid_c1", 64'(ar_valid_o), 64'd1);
        chk("rd_ar_addr", ar_addr_o, 64'h18);
        chk("rd_ar_size", 64'(ar_size_o), 64'd3);
        chk("rd_ar_id", 64'(ar_id_o), 64'(ID));
        step();
        chk("rd_ar_valid_c2", 64'(ar_valid_o), 64'd0);
        chk("rd_r_ready_c2", 64'(r_ready_o), 64'd1);
        r_valid_i = 1; r_id_i = 4'(ID); r_data_i = 64'hDEADBEEF_CAFEF00D; r_resp_i = 0; r_last_i = 1;
        step();
        r_valid_i = 0;
        chk("rd_rsp_valid_c3", 64'(rsp_valid_o), 64'd1);
        step();

        // AW delayed 3 cycles, W immediate
        aw_ready_i = 0; w_ready_i = 1;
        push_exp('0, 2'b00, 1'b0);
        issue(1'b1, 64'h20, 64'hA5A5);
        chk("awd_w_valid_c1", 64'(w_valid_o), 64'd1);
        step();
        chk("awd_w_valid_c2", 64'(w_valid_o), 64'd0);
        chk("awd_aw_valid_c2", 64'(aw_valid_o), 64'd1);
        step();
        chk("awd_aw_valid_c3", 64'(aw_valid_o), 64'd1);
        chk("awd_b_ready_c3", 64'(b_ready_o), 64'd0);
        step();
        aw_ready_i = 1;
        chk("awd_aw_valid_c4", 64'(aw_valid_o), 64'd1);
        step();
        chk("awd_aw_valid_c5", 64'(aw_valid_o), 64'd0);
        chk("awd_b_ready_c5", 64'(b_ready_o), 64'd1);
        b_valid_i = 1; b_id_i = 4'(ID); b_resp_i = 2'b00;
        step();
        b_valid_i = 0;
        chk("awd_b_ready_c6", 64'(b_ready_o), 64'd0);
        chk("awd_rsp_valid_c6", 64'(rsp_valid_o), 64'd1);
        step();

        // wrong-ID B then matching SLVERR B
        aw_ready_i = 1; w_ready_i = 1;
        push_exp('0, 2'b10, 1'b0);
        issue(1'b1, 64'h28, 64'h7);
        step();
        b_valid_i = 1; b_id_i = 4'(ID + 2); b_resp_i = 2'b00;
        step();
        chk("bid_b_ready_after_foreign", 64'(b_ready_o), 64'd1);
        chk("bid_rsp_valid_after_foreign", 64'(rsp_valid_o), 64'd0);
        b_id_i = 4'(ID); b_resp_i = 2'b10;
        step();
        b_valid_i = 0;
        chk("bid_rsp_valid", 64'(rsp_valid_o), 64'd1);
        step();

        // read watchdog: no R beat for 20 cycles
        ar_ready_i = 1;
        push_exp('0, 2'b10, 1'b1);
        issue(1'b0, 64'h30, '0);
        step();
        for (int k = 0; k < TMO + 1; k++) begin
            chk($sformatf("tmo_rsp_quiet_%0d", k), 64'(rsp_valid_o), 64'd0);
            step();
        end
        chk("tmo_rsp_valid", 64'(rsp_valid_o), 64'd1);
        chk("tmo_r_ready_drain", 64'(r_ready_o), 64'd1);
        for (int k = 0; k < 11; k++) begin
            step();
            chk($sformatf("tmo_drain_req_ready_%0d", k), 64'(req_ready_o), 64'd0);
        end
        chk("tmo_drain_rsp_valid", 64'(rsp_valid_o), 64'd0);
        r_valid_i = 1; r_id_i = 4'(ID); r_data_i = 64'h1234; r_resp_i = 0; r_last_i = 1;
        step();
        r_valid_i = 0;
        chk("tmo_late_r_ready", 64'(r_ready_o), 64'd0);
        chk("tmo_late_req_ready", 64'(req_ready_o), 64'd1);
        chk("tmo_late_rsp_valid", 64'(rsp_valid_o), 64'd0);
        step();
        chk("tmo_late_rsp_valid2", 64'(rsp_valid_o), 64'd0);

        // reset mid-write, then a normal read
        aw_ready_i = 0; w_ready_i = 0;
        issue(1'b1, 64'h40, 64'h99);
        chk("mrst_aw_valid_pre", 64'(aw_valid_o), 64'd1);
        #2 rst_ni = 1'b0;
        #1;
        chk("mrst_aw_valid", 64'(aw_valid_o), 64'd0);
        chk("mrst_w_valid", 64'(w_valid_o), 64'd0);
        chk("mrst_req_ready", 64'(req_ready_o), 64'd0);
        chk("mrst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        step();
        rst_ni = 1'b1;
        step();
        chk("mrst_req_ready_after", 64'(req_ready_o), 64'd1);
        ar_ready_i = 1;
        push_exp(64'h55AA_0F0F_1234_5678, 2'b00, 1'b0);
        issue(1'b0, 64'h08, '0);
        chk("mrst_ar_valid", 64'(ar_valid_o), 64'd1);
        step();
        r_valid_i = 1; r_id_i = 4'(ID); r_data_i = 64'h55AA_0F0F_1234_5678; r_resp_i = 0; r_last_i = 1;
        step();
        r_valid_i = 0;
        chk("mrst_rsp_valid_c3", 64'(rsp_valid_o), 64'd1);
        step();
        step();

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
